uart_cmd_parser: RTL and testbench
==================================

Name: uart_cmd_parser

Overview:
- Controller that sequences the UART receiver and turns its byte stream into command transactions for the downstream debug/programming logic.
- Gates the receiver enable and hunts for a sync byte.
- Collects a fixed 5-byte frame, verifies its checksum, and presents one command on a valid/ready interface.
- Detects inter-byte timeout, checksum errors, overruns and BREAK; keeps error status and a saturating error count for the host-visible status register.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CYCLES, 270000, max clk cycles between consecutive frame bytes (10 ms at 27 MHz); minimum legal value 2
ERR_CNT_W, 8, width of the saturating error counter

Ports:
clk  in  1  system clock
resetn  in  1  reset; one clock, reset is synchronous and active-low
enable  in  1  parser enable; low forces HUNT, clears timeout counter
rx_en  out  1  enable to the UART receiver; equals enable, registered
rx_valid  in  1  one-cycle pulse: received byte available
rx_data  in  8  received byte, valid with rx_valid
rx_break  in  1  BREAK indication, coincident with rx_valid
cmd_valid  out  1  command available
cmd_ready  in  1  consumer accepts command
cmd_op  out  8  command opcode
cmd_addr  out  8  command address
cmd_data  out  8  command data
err_pulse  out  1  one-cycle pulse on any error
err_code  out  2  last error: 0 none, 1 timeout, 2 bad checksum, 3 overrun
err_count  out  ERR_CNT_W  saturating count of errors

Behaviour:
- Frame layout: SYNC, OP, ADDR, DATA, CHK; CHK = OP ^ ADDR ^ DATA.
- Reset (resetn low at a clk edge): state HUNT; rx_en, cmd_valid, cmd_op, cmd_addr, cmd_data, err_pulse, err_code and err_count all 0; timeout counter 0. Reset mid-frame or mid-ISSUE discards everything.
- rx_en is enable delayed one cycle.
- States: HUNT, GET_OP, GET_ADDR, GET_DATA, GET_CHK, ISSUE.
- HUNT: on rx_valid with rx_data == SYNC_BYTE, go to GET_OP. Any other byte is discarded silently; this is not an error.
- GET_OP / GET_ADDR / GET_DATA: on rx_valid, latch the byte into the cmd_op / cmd_addr / cmd_data holding register respectively, then advance.
- GET_CHK: on rx_valid, if the byte equals the XOR, go to ISSUE. cmd_valid goes high the cycle after the CHK byte's rx_valid (latency 1). On mismatch: err code 2, go to HUNT.
- ISSUE:
  - cmd_valid held high; cmd_op, cmd_addr and cmd_data stable until a cycle with cmd_valid && cmd_ready.
  - The next cycle after that handshake: cmd_valid = 0, state HUNT.
  - Any rx_valid while in ISSUE, including the handshake cycle: byte dropped, err code 3, state unchanged.
- Timeout: the counter increments each cycle in GET_OP..GET_CHK and clears on rx_valid or state change. When it reaches TIMEOUT_CYCLES-1 without rx_valid: err code 1, go to HUNT. If expiry and rx_valid occur in the same cycle, the byte wins; no timeout.
- BREAK: rx_valid && rx_break in GET_OP..GET_CHK causes HUNT with no error; the break takes priority over the data byte. In HUNT, a break is ignored. In ISSUE, a break is ignored with no overrun flagged; the command completes normally.
- enable low: next state HUNT from any state except ISSUE. ISSUE completes its handshake, then stays in HUNT while enable is low. rx_valid is ignored while enable is low.
- Error reporting: on error, err_pulse = 1 for exactly one cycle (registered, the cycle after the detecting event) and err_code is updated. err_count increments by 1 and saturates at all-ones. Errors hold until reset. Only one error can occur per cycle.

Test Plan:
- Bytes A5 01 10 33 22, cmd_ready = 1 → cmd_valid 1 cycle after the 22 byte with op=01, addr=10, data=33; one-cycle pulse; state HUNT; err_count = 0.
- Bytes A5 01 10 33 23 → no cmd_valid; err_pulse once; err_code = 2; err_count = 1.
- Bytes A5 01, then idle for TIMEOUT_CYCLES (set to 100) → err_code = 1 after 100 cycles. A following full frame A5 02 20 44 66 is accepted.
- Valid frame with cmd_ready = 0 for 50 cycles; byte 55 injected in cycle 10 → cmd fields stable for 50 cycles; err_code = 3; command delivered when cmd_ready = 1.
- Bytes A5 01, then rx_valid with rx_break and data 00, then A5 07 08 09 06 → first frame dropped with no error; second frame delivered as op=07, addr=08, data=09.
- Bytes 00 FF 5A, then 300 overrun bytes while stalled → no commands; err_count saturates at 255.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// Turns a UART byte stream into command transactions. A frame is SYNC, OP, ADDR, DATA, CHK.
// Timeout, bad-checksum and overrun errors are recorded in a sticky code and a saturating count.
module uart_cmd_parser #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 270000,
  parameter int         ERR_CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 enable,
  output logic                 rx_en,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  input  logic                 rx_break,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [7:0]           cmd_op,
  output logic [7:0]           cmd_addr,
  output logic [7:0]           cmd_data,
  output logic                 err_pulse,
  output logic [1:0]           err_code,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
  localparam logic [1:0] ERR_CHECKSUM = 2'd2;
  localparam logic [1:0] ERR_OVERRUN  = 2'd3;

  typedef enum logic [2:0] {
    HUNT     = 3'd0,
    GET_OP   = 3'd1,
    GET_ADDR = 3'd2,
    GET_DATA = 3'd3,
    GET_CHK  = 3'd4,
    ISSUE    = 3'd5
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] to_cnt, to_cnt_next;
  logic [7:0]       op_next, addr_next, data_next;
  logic             err_det;
  logic [1:0]       err_det_code;
  logic             byte_in;

  // Bytes arriving while the parser is disabled are invisible to every state.
  assign byte_in   = rx_valid && enable;
  assign cmd_valid = (state == ISSUE);

  always_comb begin
    state_next   = state;
    to_cnt_next  = '0;
    op_next      = cmd_op;
    addr_next    = cmd_addr;
    data_next    = cmd_data;
    err_det      = 1'b0;
    err_det_code = 2'd0;

    case (state)
      HUNT: begin
        if (byte_in && !rx_break && (rx_data == SYNC_BYTE)) begin
          state_next = GET_OP;
        end
      end

      GET_OP, GET_ADDR, GET_DATA, GET_CHK: begin
        if (!enable || (rx_valid && rx_break)) begin
          state_next = HUNT;
        end else if (rx_valid) begin
          // A byte arriving in the expiry cycle still counts, so it is checked first.
          case (state)
            GET_OP: begin
              op_next    = rx_data;
              state_next = GET_ADDR;
            end
            GET_ADDR: begin
              addr_next  = rx_data;
              state_next = GET_DATA;
            end
            GET_DATA: begin
              data_next  = rx_data;
              state_next = GET_CHK;
            end
            default: begin
              if (rx_data == (cmd_op ^ cmd_addr ^ cmd_data)) begin
                state_next = ISSUE;
              end else begin
                state_next   = HUNT;
                err_det      = 1'b1;
                err_det_code = ERR_CHECKSUM;
              end
            end
          endcase
        end else if (to_cnt == TO_LAST) begin
          state_next   = HUNT;
          err_det      = 1'b1;
          err_det_code = ERR_TIMEOUT;
        end else begin
          to_cnt_next = to_cnt + 1'b1;
        end
      end

      ISSUE: begin
        if (cmd_ready) begin
          state_next = HUNT;
        end
        // A BREAK during ISSUE is not an overrun; the pending command just completes.
        if (byte_in && !rx_break) begin
          err_det      = 1'b1;
          err_det_code = ERR_OVERRUN;
        end
      end

      default: begin
        state_next = HUNT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= HUNT;
      to_cnt    <= '0;
      rx_en     <= 1'b0;
      cmd_op    <= 8'h00;
      cmd_addr  <= 8'h00;
      cmd_data  <= 8'h00;
      err_pulse <= 1'b0;
      err_code  <= 2'd0;
      err_count <= '0;
    end else begin
      state     <= state_next;
      to_cnt    <= to_cnt_next;
      rx_en     <= enable;
      cmd_op    <= op_next;
      cmd_addr  <= addr_next;
      cmd_data  <= data_next;
      err_pulse <= err_det;
      if (err_det) begin
        err_code <= err_det_code;
        if (err_count != {ERR_CNT_W{1'b1}}) begin
          err_count <= err_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser with a 100-cycle inter-byte timeout.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_uart_cmd_parser;

  logic       clk = 1'b0;
  logic       resetn;
  logic       enable;
  logic       rx_en;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_break;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_op;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       err_pulse;
  logic [1:0] err_code;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

  uart_cmd_parser #(
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (100),
    .ERR_CNT_W      (8)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .enable    (enable),
    .rx_en     (rx_en),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_break  (rx_break),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .err_pulse (err_pulse),
    .err_code  (err_code),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic brk);
    rx_valid = 1'b1;
    rx_data  = b;
    rx_break = brk;
    tick();
    rx_valid = 1'b0;
    rx_break = 1'b0;
    $display("rx byte %h brk=%0d -> cmd_valid=%0d err_code=%0d err_count=%0d",
             b, brk, cmd_valid, err_code, err_count);
  endtask

  task automatic test_reset();
    resetn = 1'b0; enable = 1'b1; cmd_ready = 1'b1;
    rx_valid = 1'b0; rx_data = 8'h00; rx_break = 1'b0;
    tick(); tick();
    checks++;
    if ({rx_en, cmd_valid, err_pulse} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b expected 000", {rx_en, cmd_valid, err_pulse});
    end
    checks++;
    if ({cmd_op, cmd_addr, cmd_data} !== 24'h0) begin
      errors++; $display("FAIL reset_fields: got %h expected 000000", {cmd_op, cmd_addr, cmd_data});
    end
    checks++;
    if ({err_code, err_count} !== 10'h0) begin
      errors++; $display("FAIL reset_err: code %0d count %0d expected 0 0", err_code, err_count);
    end
    resetn = 1'b1;
    tick();
    checks++;
    if (rx_en !== 1'b1) begin
      errors++; $display("FAIL rx_en_after_reset: got %b expected 1", rx_en);
    end
  endtask

  task automatic test_good_frame();
    cmd_ready = 1'b1;
    send_byte(8'hA5, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h10, 1'b0); send_byte(8'h33, 1'b0);
    checks++;
    if (cmd_valid !== 1'b0) begin
      errors++; $display("FAIL good_early_valid: got %b expected 0", cmd_valid);
    end
    send_byte(8'h22, 1'b0);
    checks++;
    if ({cmd_valid, cmd_op, cmd_addr, cmd_data} !== {1'b1, 8'h01, 8'h10, 8'h33}) begin
      errors++; $display("FAIL good_cmd: got v=%b %h %h %h expected v=1 01 10 33",
                         cmd_valid, cmd_op, cmd_addr, cmd_data);
    end
    tick();
    checks++;
    if (cmd_valid !== 1'b0) begin
      errors++; $display("FAIL good_pulse_width: got %b expected 0", cmd_valid);
    end
    checks++;
    if ({err_pulse, err_count} !== 9'h0) begin
      errors++; $display("FAIL good_no_err: pulse %b count %0d expected 0 0", err_pulse, err_count);
    end
  endtask

  task automatic test_bad_checksum();
    send_byte(8'hA5, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h10, 1'b0); send_byte(8'h33, 1'b0);
    send_byte(8'h23, 1'b0);
    checks++;
    if ({cmd_valid, err_pulse, err_code, err_count} !== {1'b0, 1'b1, 2'd2, 8'd1}) begin
      errors++; $display("FAIL bad_chk: got v=%b pulse=%b code=%0d count=%0d expected 0 1 2 1",
                         cmd_valid, err_pulse, err_code, err_count);
    end
    tick();
    checks++;
    if ({cmd_valid, err_pulse} !== 2'b00) begin
      errors++; $display("FAIL bad_chk_pulse_width: got v=%b pulse=%b expected 0 0", cmd_valid, err_pulse);
    end
  endtask

  task automatic test_timeout();
    send_byte(8'hA5, 1'b0); send_byte(8'h01, 1'b0);
    repeat (99) tick();
    checks++;
    if ({err_pulse, err_code} !== {1'b0, 2'd2}) begin
      errors++; $display("FAIL timeout_early: pulse %b code %0d expected 0 2", err_pulse, err_code);
    end
    tick();
    checks++;
    if ({err_pulse, err_code, err_count} !== {1'b1, 2'd1, 8'd2}) begin
      errors++; $display("FAIL timeout: pulse %b code %0d count %0d expected 1 1 2",
                         err_pulse, err_code, err_count);
    end
    send_byte(8'hA5, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h20, 1'b0); send_byte(8'h44, 1'b0);
    send_byte(8'h66, 1'b0);
    checks++;
    if ({cmd_valid, cmd_op, cmd_addr, cmd_data} !== {1'b1, 8'h02, 8'h20, 8'h44}) begin
      errors++; $display("FAIL after_timeout_cmd: got v=%b %h %h %h expected v=1 02 20 44",
                         cmd_valid, cmd_op, cmd_addr, cmd_data);
    end
    tick();
  endtask

  task automatic test_timeout_boundary();
    // Byte lands in the very cycle the counter reaches its limit: the byte wins.
    send_byte(8'hA5, 1'b0);
    repeat (99) tick();
    send_byte(8'h01, 1'b0);
    checks++;
    if ({err_pulse, err_count} !== {1'b0, 8'd2}) begin
      errors++; $display("FAIL timeout_boundary: pulse %b count %0d expected 0 2", err_pulse, err_count);
    end
    send_byte(8'h10, 1'b0); send_byte(8'h33, 1'b0); send_byte(8'h22, 1'b0);
    checks++;
    if ({cmd_valid, cmd_op} !== {1'b1, 8'h01}) begin
      errors++; $display("FAIL timeout_boundary_cmd: got v=%b op=%h expected v=1 op=01", cmd_valid, cmd_op);
    end
    tick();
  endtask

  task automatic test_stall();
    cmd_ready = 1'b0;
    send_byte(8'hA5, 1'b0); send_byte(8'h03, 1'b0); send_byte(8'h30, 1'b0); send_byte(8'h0C, 1'b0);
    send_byte(8'h3F, 1'b0);
    for (int i = 0; i < 50; i++) begin
      if (i == 10) send_byte(8'h55, 1'b0);
      else if (i == 20) send_byte(8'h00, 1'b1);
      else tick();
      checks++;
      if ({cmd_valid, cmd_op, cmd_addr, cmd_data} !== {1'b1, 8'h03, 8'h30, 8'h0C}) begin
        errors++; $display("FAIL stall_hold cycle %0d: got v=%b %h %h %h expected v=1 03 30 0c",
                           i, cmd_valid, cmd_op, cmd_addr, cmd_data);
      end
      if (i == 10 || i == 11 || i == 20) begin
        checks++;
        if (err_pulse !== (i == 10)) begin
          errors++; $display("FAIL stall_err_pulse cycle %0d: got %b expected %b", i, err_pulse, (i == 10));
        end
      end
    end
    checks++;
    if ({err_code, err_count} !== {2'd3, 8'd3}) begin
      errors++; $display("FAIL stall_overrun: code %0d count %0d expected 3 3", err_code, err_count);
    end
    cmd_ready = 1'b1;
    tick();
    checks++;
    if (cmd_valid !== 1'b0) begin
      errors++; $display("FAIL stall_release: got %b expected 0", cmd_valid);
    end
  endtask

  task automatic test_break();
    send_byte(8'hA5, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b1);
    checks++;
    if ({cmd_valid, err_pulse, err_count} !== {1'b0, 1'b0, 8'd3}) begin
      errors++; $display("FAIL break_no_err: v=%b pulse=%b count=%0d expected 0 0 3",
                         cmd_valid, err_pulse, err_count);
    end
    send_byte(8'hA5, 1'b0); send_byte(8'h07, 1'b0); send_byte(8'h08, 1'b0); send_byte(8'h09, 1'b0);
    send_byte(8'h06, 1'b0);
    checks++;
    if ({cmd_valid, cmd_op, cmd_addr, cmd_data} !== {1'b1, 8'h07, 8'h08, 8'h09}) begin
      errors++; $display("FAIL break_second_cmd: got v=%b %h %h %h expected v=1 07 08 09",
                         cmd_valid, cmd_op, cmd_addr, cmd_data);
    end
    tick();
  endtask

  task automatic test_enable();
    send_byte(8'hA5, 1'b0);
    enable = 1'b0;
    #1;
    checks++;
    if (rx_en !== 1'b1) begin
      errors++; $display("FAIL rx_en_delay: got %b expected 1", rx_en);
    end
    tick();
    checks++;
    if (rx_en !== 1'b0) begin
      errors++; $display("FAIL rx_en_low: got %b expected 0", rx_en);
    end
    send_byte(8'hA5, 1'b0);
    enable = 1'b1;
    tick();
    send_byte(8'h01, 1'b0); send_byte(8'h10, 1'b0); send_byte(8'h33, 1'b0); send_byte(8'h22, 1'b0);
    checks++;
    if ({cmd_valid, err_count} !== {1'b0, 8'd3}) begin
      errors++; $display("FAIL enable_abort: v=%b count=%0d expected 0 3", cmd_valid, err_count);
    end
  endtask

  task automatic test_saturation();
    cmd_ready = 1'b0;
    send_byte(8'hA5, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'hFF, 1'b0); send_byte(8'h5A, 1'b0);
    send_byte(8'hA5, 1'b0);
    for (int i = 0; i < 300; i++) send_byte(8'(i), 1'b0);
    checks++;
    if ({err_code, err_count} !== {2'd3, 8'd255}) begin
      errors++; $display("FAIL saturation: code %0d count %0d expected 3 255", err_code, err_count);
    end
    checks++;
    if ({cmd_valid, cmd_op, cmd_addr, cmd_data} !== {1'b1, 8'h00, 8'hFF, 8'h5A}) begin
      errors++; $display("FAIL saturation_hold: got v=%b %h %h %h expected v=1 00 ff 5a",
                         cmd_valid, cmd_op, cmd_addr, cmd_data);
    end
    cmd_ready = 1'b1;
    tick();
    checks++;
    if (cmd_valid !== 1'b0) begin
      errors++; $display("FAIL saturation_release: got %b expected 0", cmd_valid);
    end
  endtask

  task automatic test_reset_midframe();
    send_byte(8'hA5, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h10, 1'b0);
    resetn = 1'b0;
    tick();
    checks++;
    if ({err_count, err_code, cmd_op, cmd_addr} !== 26'h0) begin
      errors++; $display("FAIL reset_mid_clear: count %0d code %0d op %h addr %h expected 0 0 00 00",
                         err_count, err_code, cmd_op, cmd_addr);
    end
    resetn = 1'b1;
    send_byte(8'h33, 1'b0); send_byte(8'h22, 1'b0);
    checks++;
    if (cmd_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid_frame: got %b expected 0", cmd_valid);
    end
    cmd_ready = 1'b0;
    send_byte(8'hA5, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h10, 1'b0); send_byte(8'h33, 1'b0);
    send_byte(8'h22, 1'b0);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    checks++;
    if ({cmd_valid, cmd_data} !== 9'h0) begin
      errors++; $display("FAIL reset_mid_issue: v=%b data=%h expected 0 00", cmd_valid, cmd_data);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_timeout();
    test_timeout_boundary();
    test_stall();
    test_break();
    test_enable();
    test_saturation();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
